// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch encodings, BHT counter states and helpers.
// Reused by decode, fetch and the branch resolve unit.
package branch_resolve_unit_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    localparam bht_cnt_e BHT_RST = WNT;

    function automatic bht_cnt_e sat_next(input bht_cnt_e c, input logic taken);
        if (taken)
            return (c == ST) ? ST : bht_cnt_e'(c + 2'd1);
        return (c == SNT) ? SNT : bht_cnt_e'(c - 2'd1);
    endfunction

    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters, async read,
// synchronous update; a same-index read sees the pre-update value.
module branch_bht
    import branch_resolve_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_pred,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic            wr_taken
);

    bht_cnt_e tbl [ENTRIES];

    assign rd_pred = tbl[rd_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl[i] <= BHT_RST;
        end else if (wr_en) begin
            tbl[wr_idx] <= sat_next(tbl[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches one cycle after issue, computes the
// redirect target, flags mispredictions and trains the BHT.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             fetch_pred,
    input  logic             in_valid,
    input  logic [6:0]       in_op,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred,
    input  logic             flush,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispred,
    output logic [XLEN-1:0]  res_target,
    output logic             res_illegal,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam int IDXW = $clog2(BHT_ENTRIES);

    logic            accept;
    logic            illegal;
    logic            legal;
    logic            taken;
    logic            mispred;
    logic [XLEN-1:0] target;
    logic            unused_pc;

    assign unused_pc = ^{fetch_pc[XLEN-1:IDXW+2], fetch_pc[1:0]};

    assign accept  = in_valid & ~flush & (in_op == OPC_BRANCH);
    assign illegal = is_illegal_f3(in_funct3);
    assign legal   = accept & ~illegal;

    always_comb begin
        taken = 1'b0;
        unique case (in_funct3)
            F3_BEQ:  taken = (in_rs1 == in_rs2);
            F3_BNE:  taken = (in_rs1 != in_rs2);
            F3_BLT:  taken = ($signed(in_rs1) <  $signed(in_rs2));
            F3_BGE:  taken = ($signed(in_rs1) >= $signed(in_rs2));
            F3_BLTU: taken = (in_rs1 <  in_rs2);
            F3_BGEU: taken = (in_rs1 >= in_rs2);
            default: taken = 1'b0;
        endcase
    end

    // Illegal encodings never redirect: taken stays 0 so target is pc+4.
    assign mispred = taken != in_pred;
    assign target  = in_pc + (taken ? in_imm : XLEN'(4));

    branch_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDXW    (IDXW)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (fetch_pc[IDXW+1:2]),
        .rd_pred  (fetch_pred),
        .wr_en    (legal),
        .wr_idx   (in_pc[IDXW+1:2]),
        .wr_taken (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_mispred <= 1'b0;
            res_target  <= '0;
            res_illegal <= 1'b0;
        end else begin
            res_valid   <= accept;
            res_taken   <= legal & taken;
            res_mispred <= legal & mispred;
            res_illegal <= accept & illegal;
            if (accept)
                res_target <= target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_branches <= '0;
            cnt_mispred  <= '0;
        end else if (legal) begin
            if (cnt_branches != '1)
                cnt_branches <= cnt_branches + CNT_W'(1);
            if (mispred && cnt_mispred != '1)
                cnt_mispred <= cnt_mispred + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit; a second instance
// with 4-bit counters exercises counter saturation.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        in_valid;
    logic [6:0]  in_op;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        in_pred;
    logic        flush;

    logic        fetch_pred;
    logic        res_valid;
    logic        res_taken;
    logic        res_mispred;
    logic [31:0] res_target;
    logic        res_illegal;
    logic [15:0] cnt_branches;
    logic [15:0] cnt_mispred;

    logic        fetch_pred4;
    logic        res_valid4;
    logic        res_taken4;
    logic        res_mispred4;
    logic [31:0] res_target4;
    logic        res_illegal4;
    logic [3:0]  cnt_branches4;
    logic [3:0]  cnt_mispred4;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] ALU = 7'b0110011;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_pc     (fetch_pc),
        .fetch_pred   (fetch_pred),
        .in_valid     (in_valid),
        .in_op        (in_op),
        .in_funct3    (in_funct3),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_pc        (in_pc),
        .in_imm       (in_imm),
        .in_pred      (in_pred),
        .flush        (flush),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .res_mispred  (res_mispred),
        .res_target   (res_target),
        .res_illegal  (res_illegal),
        .cnt_branches (cnt_branches),
        .cnt_mispred  (cnt_mispred)
    );

    branch_resolve_unit #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .fetch_pc     (fetch_pc),
        .fetch_pred   (fetch_pred4),
        .in_valid     (in_valid),
        .in_op        (in_op),
        .in_funct3    (in_funct3),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_pc        (in_pc),
        .in_imm       (in_imm),
        .in_pred      (in_pred),
        .flush        (flush),
        .res_valid    (res_valid4),
        .res_taken    (res_taken4),
        .res_mispred  (res_mispred4),
        .res_target   (res_target4),
        .res_illegal  (res_illegal4),
        .cnt_branches (cnt_branches4),
        .cnt_mispred  (cnt_mispred4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred, input logic fl);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_funct3 = f3;
        in_rs1    = a;
        in_rs2    = b;
        in_pc     = pc;
        in_imm    = imm;
        in_pred   = pred;
        flush     = fl;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic v, input logic t,
                             input logic m, input logic [31:0] tgt,
                             input logic il);
        check({tag, ".valid"},   32'(res_valid),   32'(v));
        check({tag, ".taken"},   32'(res_taken),   32'(t));
        check({tag, ".mispred"}, 32'(res_mispred), 32'(m));
        check({tag, ".target"},  res_target,       tgt);
        check({tag, ".illegal"}, 32'(res_illegal), 32'(il));
    endtask

    task automatic check_cnt(input string tag, input int br, input int mp);
        check({tag, ".cnt_br"}, 32'(cnt_branches), 32'(br));
        check({tag, ".cnt_mp"}, 32'(cnt_mispred),  32'(mp));
    endtask

    initial begin
        rst = 1'b1;
        fetch_pc = '0;
        in_valid = 1'b0;
        in_op = '0;
        in_funct3 = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_pc = '0;
        in_imm = '0;
        in_pred = 1'b0;
        flush = 1'b0;
        step;
        step;
        @(negedge clk);
        rst = 1'b0;
        step;

        check_res("reset", 0, 0, 0, 32'h0, 0);
        check_cnt("reset", 0, 0);
        check("reset.cnt4", 32'({cnt_branches4, cnt_mispred4}), 32'h0);
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 32'(i * 4);
            #1;
            check($sformatf("reset.bht%0d", i), 32'(fetch_pred), 32'h0);
        end

        // Signed vs unsigned compare of the same operands.
        issue(BR, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0, 0);
        step;
        check_res("blt", 1, 1, 1, 32'h120, 0);
        check_cnt("blt", 1, 1);
        issue(BR, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 0, 0);
        step;
        check_res("bltu", 1, 0, 0, 32'h104, 0);
        check_cnt("bltu", 2, 1);
        idle;
        step;
        check("pulse.valid", 32'(res_valid), 32'h0);

        // Three taken BEQ at 0x40, read-before-write on the first.
        issue(BR, 3'b000, 32'h5, 32'h5, 32'h40, 32'h10, 0, 0);
        fetch_pc = 32'h40;
        #1;
        check("rbw.pred", 32'(fetch_pred), 32'h0);
        step;
        check_res("beq1", 1, 1, 1, 32'h50, 0);
        check("beq1.pred", 32'(fetch_pred), 32'h1);
        issue(BR, 3'b000, 32'h5, 32'h5, 32'h40, 32'h10, 1, 0);
        step;
        check("beq2.mispred", 32'(res_mispred), 32'h0);
        check("beq2.pred", 32'(fetch_pred), 32'h1);
        issue(BR, 3'b000, 32'h5, 32'h5, 32'h40, 32'h10, 1, 0);
        step;
        check_cnt("beq3", 5, 2);
        // From saturated 11 two not-taken steps are needed to flip.
        issue(BR, 3'b001, 32'h5, 32'h5, 32'h40, 32'h10, 1, 0);
        step;
        check_res("bne1", 1, 0, 1, 32'h44, 0);
        check("bne1.pred", 32'(fetch_pred), 32'h1);
        issue(BR, 3'b001, 32'h5, 32'h5, 32'h40, 32'h10, 1, 0);
        step;
        check("bne2.pred", 32'(fetch_pred), 32'h0);
        check_cnt("bne2", 7, 4);

        // Illegal funct3.
        issue(BR, 3'b010, 32'h5, 32'h5, 32'h40, 32'h10, 1, 0);
        step;
        check_res("ill", 1, 0, 0, 32'h44, 1);
        check_cnt("ill", 7, 4);
        check("ill.pred", 32'(fetch_pred), 32'h0);
        issue(BR, 3'b011, 32'h5, 32'h6, 32'h80, 32'h10, 0, 0);
        step;
        check_res("ill3", 1, 0, 0, 32'h84, 1);

        // Flushed branch, then non-branch opcode.
        issue(BR, 3'b000, 32'h1, 32'h1, 32'h84, 32'h10, 0, 1);
        fetch_pc = 32'h84;
        step;
        check("flush.valid", 32'(res_valid), 32'h0);
        check_cnt("flush", 7, 4);
        issue(BR, 3'b000, 32'h1, 32'h1, 32'h84, 32'h10, 0, 0);
        step;
        check("flush.bht", 32'(fetch_pred), 32'h1);
        issue(ALU, 3'b000, 32'h1, 32'h1, 32'h88, 32'h10, 0, 0);
        step;
        check("alu.valid", 32'(res_valid), 32'h0);
        check_cnt("alu", 8, 5);

        // Reset dominates a valid issue.
        issue(BR, 3'b000, 32'h1, 32'h1, 32'h84, 32'h10, 0, 0);
        rst = 1'b1;
        step;
        check_res("rst", 0, 0, 0, 32'h0, 0);
        check_cnt("rst", 0, 0);
        check("rst.bht", 32'(fetch_pred), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Twenty back-to-back mispredicted branches.
        for (int i = 0; i < 20; i++)
            issue(BR, 3'b000, 32'h7, 32'h7, 32'h200, 32'h8, 0, 0);
        step;
        check("sus.valid", 32'(res_valid), 32'h1);
        check_cnt("sus", 20, 20);
        check("sat4.br", 32'(cnt_branches4), 32'hF);
        check("sat4.mp", 32'(cnt_mispred4), 32'hF);

        // Target wraps modulo 2^32.
        issue(BR, 3'b000, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1, 0);
        step;
        check_res("wrap", 1, 1, 0, 32'h4, 0);
        issue(BR, 3'b001, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 0, 0);
        step;
        check_res("wrap4", 1, 0, 0, 32'h0, 0);
        check("sat4.hold", 32'(cnt_branches4), 32'hF);
        idle;
        step;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
